load_store_ctrl: RTL and testbench
==================================

// Module: load_store_ctrl
// PURPOSE
//  Initiator side of the data-memory interface: converts pipeline load/store requests into
//  word-indexed Mem_Read/Mem_Write accesses on the 64-word data memory.
//  Handles byte/half/word sizes, little-endian lane selection, sign/zero extension,
//  read-modify-write for sub-word stores, and misalign/range errors.
//  Sits between the MEM stage and data_memory; one request in flight at a time.
// PARAMETERS
//  DEPTH    64   number of 32-bit words in the target data memory (word index range 0..DEPTH-1)
// PORTS
//  clk          in   1   system clock; all state changes on posedge
//  rst          in   1   asynchronous, active-low reset (0 = reset)
//  req_valid    in   1   pipeline presents a request
//  req_ready    out  1   controller can accept (high only in IDLE)
//  req_we       in   1   1 = store, 0 = load
//  req_size     in   2   00 byte, 01 half, 10 word, 11 reserved (treated as error)
//  req_unsigned in   1   loads: 1 = zero-extend, 0 = sign-extend; ignored for stores
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid    out  1   response available
//  rsp_ready    in   1   pipeline consumes response
//  rsp_rdata    out  32  extended load data; 0 for stores and errors
//  rsp_err      out  1   misaligned, out-of-range or reserved-size request
//  Mem_Read     out  1   read strobe to data memory
//  Mem_Write    out  1   write strobe to data memory (memory writes on posedge)
//  Read_addr    out  32  word index = req_addr[31:2], zero-extended
//  Write_Data   out  32  full merged word to write
//  Mem_data_in  in   32  combinational read data from memory (valid while Mem_Read=1)
// BEHAVIOUR
//  - Reset (rst=0): state=IDLE, all regs cleared; req_ready=1, rsp_valid=0, rsp_err=0,
//    rsp_rdata=0, Mem_Read=0, Mem_Write=0, Read_addr=0, Write_Data=0. Effect immediate (async).
//  - Accept when req_valid && req_ready at posedge T; request fields latched; req_ready=0 until
//    return to IDLE.
//  - States: IDLE, READ, WRITE, RESP. Memory outputs decode from registered state only:
//    Mem_Read=(state==READ), Mem_Write=(state==WRITE); both never high together.
//  - Error check at accept: half with addr[0]=1, word with addr[1:0]!=0, size=11, or
//    addr[31:2]>=DEPTH -> IDLE->RESP with rsp_err=1, rsp_rdata=0, no memory strobe. RESP at T+1.
//  - Load: IDLE->READ->RESP. In READ, Mem_data_in captured at posedge; lane picked by addr[1:0]
//    (byte) or addr[1] (half), then extended. rsp_valid first high at T+2.
//  - Word store: IDLE->WRITE->RESP. Write_Data=req_wdata. RESP at T+2.
//  - Byte/half store: IDLE->READ->WRITE->RESP (read-modify-write). Captured word with the target
//    lane(s) replaced by req_wdata[7:0]/[15:0]; other lanes preserved. RESP at T+3.
//  - RESP: rsp_valid=1, rsp_rdata/rsp_err held stable until rsp_valid && rsp_ready at a posedge,
//    then ->IDLE; next request accepted no earlier than the following posedge
//    (no same-cycle response/accept overlap).
//  - Read_addr/Write_Data held constant from READ through WRITE; Read_addr returns to 0 in IDLE.
//  - Reset asserted mid-operation: strobes drop immediately, pending write aborted (memory
//    unchanged), pending response discarded.
//  - req_* inputs ignored outside IDLE; rsp_ready ignored outside RESP.
// TESTING
//  1. Hold rst=0 3 cycles, release -> req_ready=1, rsp_valid=0, Mem_Read=Mem_Write=0, Read_addr=0.
//  2. mem[17]=56; lw addr 0x44 -> T+1 Mem_Read=1, Read_addr=17; T+2 rsp_rdata=0x00000038,
//     rsp_err=0.
//  3. mem[15]=0x00000041; sb addr 0x3D data 0xAB -> T+1 Mem_Read=1 Read_addr=15;
//     T+2 Mem_Write=1 Write_Data=0x0000AB41; T+3 rsp_valid=1.
//  4. Then lb 0x3D -> rsp_rdata=0xFFFFFFAB; lbu 0x3D -> 0x000000AB;
//     lhu 0x3C -> 0x0000AB41.
//  5. lw 0x42 -> T+1 rsp_err=1, rsp_rdata=0, no strobe; sw 0x100 (index 64) -> rsp_err=1,
//     Mem_Write never high.
//  6. rsp_ready=0 for 3 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0;
//     sw 0x70 data 0x1234 with rst=0 during WRITE -> Mem_Write drops at once, mem[28] unchanged.

Source files
------------

// File: rtl/load_store_ctrl.sv
// Data-memory initiator: pipeline load/store -> word-indexed Mem_Read/Mem_Write, one request in flight.
// Latency: error 1, load/word store 2, sub-word store 3 (RMW); response held until rsp_ready.
module load_store_ctrl #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic [31:0] Read_addr,
  output logic [31:0] Write_Data,
  input  logic [31:0] Mem_data_in
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state, next_state;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wword_q, rdata_q;
  logic [15:0] wdata_q;
  logic        req_err;
  logic [4:0]  shift;
  logic [31:0] lane, load_val, merge_val;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
      SZ_BYTE: req_err = 1'b0;
      default: req_err = 1'b1;
    endcase
    if (req_addr[31:2] >= 30'(DEPTH)) req_err = 1'b1;
  end

  // Lane extraction for loads and lane replacement for sub-word stores share one shifter.
  always_comb begin
    shift     = {addr_q[1:0], 3'b000};
    lane      = Mem_data_in >> shift;
    load_val  = lane;
    merge_val = Mem_data_in;
    case (size_q)
      SZ_BYTE: begin
        load_val  = {{24{~uns_q & lane[7]}}, lane[7:0]};
        merge_val = (Mem_data_in & ~(32'h0000_00FF << shift)) | ({24'b0, wdata_q[7:0]} << shift);
      end
      SZ_HALF: begin
        load_val  = {{16{~uns_q & lane[15]}}, lane[15:0]};
        merge_val = (Mem_data_in & ~(32'h0000_FFFF << shift)) | ({16'b0, wdata_q} << shift);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = 32'b0;
    rsp_err    = 1'b0;
    Mem_Read   = 1'b0;
    Mem_Write  = 1'b0;
    Read_addr  = 32'b0;
    Write_Data = 32'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                          next_state = RESP;
          else if (req_we && req_size == SZ_WORD) next_state = WRITE;
          else                                  next_state = READ;
        end
      end
      READ: begin
        Mem_Read   = 1'b1;
        Read_addr  = {2'b00, addr_q[31:2]};
        Write_Data = we_q ? merge_val : 32'b0;
        next_state = we_q ? WRITE : RESP;
      end
      WRITE: begin
        Mem_Write  = 1'b1;
        Read_addr  = {2'b00, addr_q[31:2]};
        Write_Data = wword_q;
        next_state = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'b0;
      wdata_q <= 16'b0;
      wword_q <= 32'b0;
      rdata_q <= 32'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          uns_q   <= req_unsigned;
          err_q   <= req_err;
          size_q  <= req_size;
          addr_q  <= req_addr;
          wdata_q <= req_wdata[15:0];
          wword_q <= req_wdata;
          rdata_q <= 32'b0;
        end
        READ: begin
          if (we_q) wword_q <= merge_val;
          else      rdata_q <= load_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_ctrl.sv
// Bench for load_store_ctrl: word-array memory model, per-cycle protocol/data compare, directed vectors.
module tb_load_store_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_we, req_unsigned, rsp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, Mem_data_in;
  logic        req_ready, rsp_valid, rsp_err, Mem_Read, Mem_Write;
  logic [31:0] rsp_rdata, Read_addr, Write_Data;

  int n_chk = 0;
  int n_fail = 0;

  load_store_ctrl #(.DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Read_addr(Read_addr),
    .Write_Data(Write_Data), .Mem_data_in(Mem_data_in)
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 17) return 32'd56;
    if (i == 15) return 32'h0000_0041;
    if (i == 28) return 32'hCAFE_0028;
    return (i * 32'h0101_0103) ^ 32'h8A5C_3E71;
  endfunction

  // Target data memory: combinational read, posedge write.
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        preload = 1'b1;
  assign Mem_data_in = mem[Read_addr[5:0]];
  always @(posedge clk) begin
    if (preload) for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    else if (Mem_Write) mem[Read_addr[5:0]] <= Write_Data;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Expected transaction: k counts posedges since accept (k=1 is the first cycle after it).
  logic        checking = 1'b0;
  logic        busy = 1'b0;
  int          k = 0;
  int          m_lat, m_wk;
  logic        m_read, m_err;
  logic [31:0] m_idx, m_rdata, m_wword;
  logic [31:0] last_rdata, last_wd, last_ra;
  logic        last_err;

  always @(negedge clk) begin
    if (checking) begin
      logic e_rd, e_wr, e_rv;
      e_rd = busy && k == 1 && m_read;
      e_wr = busy && m_wk != 0 && k == m_wk;
      e_rv = busy && k >= m_lat;
      chk("req_ready", {31'b0, req_ready}, {31'b0, !busy});
      chk("Mem_Read", {31'b0, Mem_Read}, {31'b0, e_rd});
      chk("Mem_Write", {31'b0, Mem_Write}, {31'b0, e_wr});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_rv});
      if (e_rd || e_wr) chk("Read_addr", Read_addr, m_idx);
      if (!busy) chk("Read_addr_idle", Read_addr, 32'd0);
      if (e_wr) chk("Write_Data", Write_Data, m_wword);
      if (e_rv) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
      end
    end
  end

  task automatic sample();
    if (Mem_Write) last_wd = Write_Data;
    if (Mem_Read || Mem_Write) last_ra = Read_addr;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int stall);
    logic [31:0] w, b, nw;
    int sh;
    m_idx = addr >> 2;
    m_err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
            (size == 2'd2 && addr % 4 != 0) || (m_idx >= 64);
    w  = (m_idx < 64) ? ref_mem[m_idx[5:0]] : 32'd0;
    sh = (addr % 4) * 8;
    m_rdata = 32'd0;
    nw = w;
    if (!m_err && !we) begin
      if (size == 2'd0) begin
        b = (w >> sh) & 32'hFF;
        m_rdata = (!uns && b >= 128) ? b + 32'hFFFF_FF00 : b;
      end else if (size == 2'd1) begin
        b = (w >> sh) & 32'hFFFF;
        m_rdata = (!uns && b >= 32768) ? b + 32'hFFFF_0000 : b;
      end else m_rdata = w;
    end
    if (!m_err && we) begin
      if (size == 2'd0)      nw = (w & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
      else if (size == 2'd1) nw = (w & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
      else                   nw = wdata;
    end
    m_wword = nw;
    m_read  = !m_err && !(we && size == 2'd2);
    m_wk    = (m_err || !we) ? 0 : (size == 2'd2 ? 1 : 2);
    m_lat   = m_err ? 1 : ((we && size != 2'd2) ? 3 : 2);
    last_wd = 32'd0;
    last_ra = 32'd0;

    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    busy = 1'b1; k = 1;
    // Garbage on the request bus and an early rsp_ready must both be ignored while busy.
    req_we = ~we; req_size = ~size; req_addr = $urandom; req_wdata = $urandom;
    rsp_ready = 1'b1;
    sample();
    while (k < m_lat) begin
      @(posedge clk); #1; k++; sample();
    end
    if (stall > 0) begin
      rsp_ready = 1'b0;
      repeat (stall) begin @(posedge clk); #1; k++; end
    end
    last_rdata = rsp_rdata;
    last_err   = rsp_err;
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    busy = 1'b0; rsp_ready = 1'b0;
    if (!m_err && we) ref_mem[m_idx[5:0]] = m_wword;
    if (m_idx < 64) chk("mem_word", mem[m_idx[5:0]], ref_mem[m_idx[5:0]]);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_Mem_Read", {31'b0, Mem_Read}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1; preload = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid2", {31'b0, rsp_valid}, 32'd0);
    chk("rst_strobes", {30'b0, Mem_Read, Mem_Write}, 32'd0);
    chk("rst_Read_addr", Read_addr, 32'd0);
    chk("rst_Write_Data", Write_Data, 32'd0);
    chk("rst_rsp", {rsp_rdata[30:0], rsp_err}, 32'd0);
    checking = 1'b1;

    do_req(1'b0, 2'b10, 1'b0, 32'h44, 32'd0, 0);
    chk("lw44_rdata", last_rdata, 32'h0000_0038);
    chk("lw44_raddr", last_ra, 32'd17);
    chk("model_lw44", m_rdata, 32'h0000_0038);

    do_req(1'b1, 2'b00, 1'b0, 32'h3D, 32'h0000_00AB, 0);
    chk("sb3d_wdata", last_wd, 32'h0000_AB41);
    chk("sb3d_raddr", last_ra, 32'd15);

    do_req(1'b0, 2'b00, 1'b0, 32'h3D, 32'd0, 0);
    chk("lb3d", last_rdata, 32'hFFFF_FFAB);
    do_req(1'b0, 2'b00, 1'b1, 32'h3D, 32'd0, 0);
    chk("lbu3d", last_rdata, 32'h0000_00AB);
    do_req(1'b0, 2'b01, 1'b1, 32'h3C, 32'd0, 0);
    chk("lhu3c", last_rdata, 32'h0000_AB41);
    do_req(1'b0, 2'b01, 1'b0, 32'h3C, 32'd0, 0);
    chk("lh3c", last_rdata, 32'hFFFF_AB41);

    do_req(1'b0, 2'b10, 1'b0, 32'h42, 32'd0, 0);
    chk("lw42_err", {31'b0, last_err}, 32'd1);
    chk("lw42_rdata", last_rdata, 32'd0);
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h5555_5555, 0);
    chk("sw100_err", {31'b0, last_err}, 32'd1);
    do_req(1'b0, 2'b11, 1'b0, 32'h20, 32'd0, 0);
    chk("rsvd_err", {31'b0, last_err}, 32'd1);
    do_req(1'b0, 2'b01, 1'b1, 32'h21, 32'd0, 0);
    chk("lh_odd_err", {31'b0, last_err}, 32'd1);

    do_req(1'b0, 2'b10, 1'b0, 32'h44, 32'd0, 3);
    chk("lw44_stall", last_rdata, 32'h0000_0038);
    do_req(1'b1, 2'b01, 1'b0, 32'h46, 32'h1234_5678, 1);
    chk("sh46_wdata", last_wd, 32'h5678_0038);
    do_req(1'b0, 2'b10, 1'b0, 32'h44, 32'd0, 0);
    chk("lw44_after_sh", last_rdata, 32'h5678_0038);
    do_req(1'b0, 2'b01, 1'b0, 32'h46, 32'd0, 0);
    chk("lh46", last_rdata, 32'h0000_5678);
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 2);
    chk("lw10", last_rdata, 32'hDEAD_BEEF);
    do_req(1'b1, 2'b00, 1'b0, 32'hFF, 32'h0000_0080, 0);
    do_req(1'b0, 2'b00, 1'b0, 32'hFF, 32'd0, 0);
    chk("lb_ff", last_rdata, 32'hFFFF_FF80);
    do_req(1'b0, 2'b10, 1'b0, 32'hFC, 32'd0, 0);
    chk("lw_fc_err", {31'b0, last_err}, 32'd0);

    // Reset during the WRITE cycle of a word store must abort it.
    checking = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h70; req_wdata = 32'h0000_1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_Mem_Write_on", {31'b0, Mem_Write}, 32'd1);
    chk("abort_Read_addr", Read_addr, 32'd28);
    #2 rst = 1'b0;
    #1;
    chk("abort_Mem_Write_off", {31'b0, Mem_Write}, 32'd0);
    chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("abort_mem28", mem[28], ref_mem[28]);
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
